// File: rtl/mips_cpu_definitions.sv
// -----------------------------------------------------------------------------
// mips_cpu_definitions
//   Shared MIPS I encodings and writeback-stage types.
//   Contents: opcode_t (primary opcode field), funct_t (R-type funct field),
//   REGIMM link sub-codes, the link register index and the writeback FSM
//   state enum wb_state_t.
// -----------------------------------------------------------------------------
package mips_cpu_definitions;

    typedef enum logic [5:0] {
        OPCODE_R      = 6'h00,
        OPCODE_REGIMM = 6'h01,
        OPCODE_J      = 6'h02,
        OPCODE_JAL    = 6'h03,
        OPCODE_BEQ    = 6'h04,
        OPCODE_BNE    = 6'h05,
        OPCODE_BLEZ   = 6'h06,
        OPCODE_BGTZ   = 6'h07,
        OPCODE_ADDI   = 6'h08,
        OPCODE_ADDIU  = 6'h09,
        OPCODE_SLTI   = 6'h0A,
        OPCODE_SLTIU  = 6'h0B,
        OPCODE_ANDI   = 6'h0C,
        OPCODE_ORI    = 6'h0D,
        OPCODE_XORI   = 6'h0E,
        OPCODE_LUI    = 6'h0F,
        OPCODE_LB     = 6'h20,
        OPCODE_LH     = 6'h21,
        OPCODE_LWL    = 6'h22,
        OPCODE_LW     = 6'h23,
        OPCODE_LBU    = 6'h24,
        OPCODE_LHU    = 6'h25,
        OPCODE_LWR    = 6'h26,
        OPCODE_SB     = 6'h28,
        OPCODE_SH     = 6'h29,
        OPCODE_SW     = 6'h2B
    } opcode_t;

    typedef enum logic [5:0] {
        FUNCT_SLL   = 6'h00,
        FUNCT_SRL   = 6'h02,
        FUNCT_SRA   = 6'h03,
        FUNCT_SLLV  = 6'h04,
        FUNCT_SRLV  = 6'h06,
        FUNCT_SRAV  = 6'h07,
        FUNCT_JR    = 6'h08,
        FUNCT_JALR  = 6'h09,
        FUNCT_MFHI  = 6'h10,
        FUNCT_MTHI  = 6'h11,
        FUNCT_MFLO  = 6'h12,
        FUNCT_MTLO  = 6'h13,
        FUNCT_MULT  = 6'h18,
        FUNCT_MULTU = 6'h19,
        FUNCT_DIV   = 6'h1A,
        FUNCT_DIVU  = 6'h1B,
        FUNCT_ADD   = 6'h20,
        FUNCT_ADDU  = 6'h21,
        FUNCT_SUB   = 6'h22,
        FUNCT_SUBU  = 6'h23,
        FUNCT_AND   = 6'h24,
        FUNCT_OR    = 6'h25,
        FUNCT_XOR   = 6'h26,
        FUNCT_NOR   = 6'h27,
        FUNCT_SLT   = 6'h2A,
        FUNCT_SLTU  = 6'h2B
    } funct_t;

    localparam logic [4:0] REGIMM_BLTZAL = 5'b10000;
    localparam logic [4:0] REGIMM_BGEZAL = 5'b10001;
    localparam logic [4:0] REG_LINK      = 5'd31;

    typedef enum logic [1:0] {
        WB_IDLE     = 2'd0,
        WB_WAIT_MEM = 2'd1,
        WB_COMMIT   = 2'd2
    } wb_state_t;

endpackage

// File: rtl/mips_cpu_load_extract.sv
// -----------------------------------------------------------------------------
// mips_cpu_load_extract
//   Combinational little-endian load data extraction and LWL/LWR merge.
//   Ports:
//     opcode_i    [5:0]  load opcode of the committing instruction
//     k_i         [1:0]  byte offset (effective address bits [1:0])
//     mem_word_i  [31:0] aligned word returned by memory
//     rt_value_i  [31:0] current rt contents, merged by LWL/LWR
//     result_o    [31:0] value to write into the destination register
// -----------------------------------------------------------------------------
module mips_cpu_load_extract
    import mips_cpu_definitions::*;
(
    input  logic [5:0]  opcode_i,
    input  logic [1:0]  k_i,
    input  logic [31:0] mem_word_i,
    input  logic [31:0] rt_value_i,
    output logic [31:0] result_o
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;
    logic [4:0]  lwl_sh_s;
    logic [4:0]  lwr_sh_s;

    // Byte lane select: byte k lives in bits [8k+7:8k]
    always_comb begin
        byte_s = 8'h00;
        case (k_i)
            2'd0:    byte_s = mem_word_i[7:0];
            2'd1:    byte_s = mem_word_i[15:8];
            2'd2:    byte_s = mem_word_i[23:16];
            2'd3:    byte_s = mem_word_i[31:24];
            default: byte_s = 8'h00;
        endcase
    end

    // Halfword select uses k[1] only; shift amounts are 8*(3-k) and 8*k,
    // and 3-k on a 2-bit value is simply its bitwise inverse
    assign half_s   = k_i[1] ? mem_word_i[31:16] : mem_word_i[15:0];
    assign lwl_sh_s = {~k_i, 3'b000};
    assign lwr_sh_s = {k_i, 3'b000};

    // Per-opcode result formation
    always_comb begin
        result_o = mem_word_i;
        case (opcode_i)
            OPCODE_LB:  result_o = {{24{byte_s[7]}}, byte_s};
            OPCODE_LBU: result_o = {24'h000000, byte_s};
            OPCODE_LH:  result_o = {{16{half_s[15]}}, half_s};
            OPCODE_LHU: result_o = {16'h0000, half_s};
            OPCODE_LW:  result_o = mem_word_i;
            OPCODE_LWL: result_o = (mem_word_i << lwl_sh_s)
                                 | (rt_value_i & ~(32'hFFFF_FFFF << lwl_sh_s));
            OPCODE_LWR: result_o = (mem_word_i >> lwr_sh_s)
                                 | (rt_value_i & ~(32'hFFFF_FFFF >> lwr_sh_s));
            default:    result_o = mem_word_i;
        endcase
    end

endmodule

// File: rtl/mips_cpu_reg_writeback.sv
// -----------------------------------------------------------------------------
// mips_cpu_reg_writeback
//   Write-side initiator for the register file. Accepts one retiring
//   instruction per handshake, resolves its destination (rd / rt / $31),
//   waits for load data when needed, and issues one registered write.
//   Ports:
//     clk, reset (async, active-high)
//     in_valid/in_ready handshake, in_opcode, in_funct, in_rt, in_rd,
//     in_alu_result, in_link_addr, in_rt_value   -- retiring instruction
//     mem_readdata, mem_readvalid                -- load data return
//     rf_write_en, rf_a3, rf_opcode, rf_writedata -- register-file write port
//   Optional build macro MIPS_WB_FORWARD_EN adds:
//     fwd_valid/fwd_reg/fwd_data  -- copy of the write port during COMMIT
//     pend_valid/pend_reg         -- load destination pending in WAIT_MEM
// -----------------------------------------------------------------------------
module mips_cpu_reg_writeback
    import mips_cpu_definitions::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [5:0]  in_opcode,
    input  logic [5:0]  in_funct,
    input  logic [4:0]  in_rt,
    input  logic [4:0]  in_rd,
    input  logic [31:0] in_alu_result,
    input  logic [31:0] in_link_addr,
    input  logic [31:0] in_rt_value,
    input  logic [31:0] mem_readdata,
    input  logic        mem_readvalid,
    output logic        rf_write_en,
    output logic [4:0]  rf_a3,
    output logic [5:0]  rf_opcode,
    output logic [31:0] rf_writedata
`ifdef MIPS_WB_FORWARD_EN
    ,
    output logic        fwd_valid,
    output logic [4:0]  fwd_reg,
    output logic [31:0] fwd_data,
    output logic        pend_valid,
    output logic [4:0]  pend_reg
`endif
);

    wb_state_t   state_q;
    logic        rf_write_en_q;
    logic [4:0]  rf_a3_q;
    logic [5:0]  rf_opcode_q;
    logic [31:0] rf_writedata_q;
    logic [1:0]  ld_k_q;
    logic [31:0] rt_value_q;

    logic        dec_write_s;
    logic        dec_load_s;
    logic [4:0]  dec_dest_s;
    logic [31:0] dec_data_s;
    logic        accept_s;
    logic        commit_s;
    logic [31:0] load_result_s;

    // Destination/data resolution of the presented instruction
    always_comb begin
        dec_write_s = 1'b0;
        dec_load_s  = 1'b0;
        dec_dest_s  = 5'd0;
        dec_data_s  = in_alu_result;
        case (in_opcode)
            OPCODE_R: begin
                case (in_funct)
                    FUNCT_JALR: begin
                        dec_write_s = 1'b1;
                        dec_dest_s  = in_rd;
                        dec_data_s  = in_link_addr;
                    end
                    FUNCT_SLL, FUNCT_SRL, FUNCT_SRA, FUNCT_SLLV, FUNCT_SRLV,
                    FUNCT_SRAV, FUNCT_MFHI, FUNCT_MFLO, FUNCT_ADD, FUNCT_ADDU,
                    FUNCT_SUB, FUNCT_SUBU, FUNCT_AND, FUNCT_OR, FUNCT_XOR,
                    FUNCT_NOR, FUNCT_SLT, FUNCT_SLTU: begin
                        dec_write_s = 1'b1;
                        dec_dest_s  = in_rd;
                    end
                    // JR, MULT/DIV family, MTHI/MTLO and unknown functs write nothing
                    default: dec_write_s = 1'b0;
                endcase
            end
            OPCODE_REGIMM: begin
                // Linking branches write $31 whether or not the branch is taken
                if ((in_rt == REGIMM_BLTZAL) || (in_rt == REGIMM_BGEZAL)) begin
                    dec_write_s = 1'b1;
                    dec_dest_s  = REG_LINK;
                    dec_data_s  = in_link_addr;
                end else begin
                    dec_write_s = 1'b0;
                end
            end
            OPCODE_JAL: begin
                dec_write_s = 1'b1;
                dec_dest_s  = REG_LINK;
                dec_data_s  = in_link_addr;
            end
            OPCODE_ADDI, OPCODE_ADDIU, OPCODE_SLTI, OPCODE_SLTIU,
            OPCODE_ANDI, OPCODE_ORI, OPCODE_XORI, OPCODE_LUI: begin
                dec_write_s = 1'b1;
                dec_dest_s  = in_rt;
            end
            OPCODE_LB, OPCODE_LH, OPCODE_LWL, OPCODE_LW,
            OPCODE_LBU, OPCODE_LHU, OPCODE_LWR: begin
                dec_write_s = 1'b1;
                dec_load_s  = 1'b1;
                dec_dest_s  = in_rt;
            end
            default: dec_write_s = 1'b0;
        endcase
    end

    assign in_ready = (state_q == WB_IDLE);
    assign accept_s = in_valid && in_ready;
    // Writes to $0 retire silently, so loads to $0 never wait for data
    assign commit_s = dec_write_s && (dec_dest_s != 5'd0);

    // Load extraction operates on fields latched at accept time
    mips_cpu_load_extract u_load_extract (
        .opcode_i   (rf_opcode_q),
        .k_i        (ld_k_q),
        .mem_word_i (mem_readdata),
        .rt_value_i (rt_value_q),
        .result_o   (load_result_s)
    );

    // Writeback FSM with registered write-port outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= WB_IDLE;
            rf_write_en_q  <= 1'b0;
            rf_a3_q        <= 5'd0;
            rf_opcode_q    <= 6'd0;
            rf_writedata_q <= 32'd0;
            ld_k_q         <= 2'd0;
            rt_value_q     <= 32'd0;
        end else begin
            case (state_q)
                WB_IDLE: begin
                    rf_write_en_q <= 1'b0;
                    if (accept_s && commit_s) begin
                        rf_a3_q     <= dec_dest_s;
                        rf_opcode_q <= in_opcode;
                        ld_k_q      <= in_alu_result[1:0];
                        rt_value_q  <= in_rt_value;
                        if (dec_load_s) begin
                            state_q <= WB_WAIT_MEM;
                        end else begin
                            rf_writedata_q <= dec_data_s;
                            rf_write_en_q  <= 1'b1;
                            state_q        <= WB_COMMIT;
                        end
                    end
                end
                WB_WAIT_MEM: begin
                    if (mem_readvalid) begin
                        rf_writedata_q <= load_result_s;
                        rf_write_en_q  <= 1'b1;
                        state_q        <= WB_COMMIT;
                    end
                end
                WB_COMMIT: begin
                    rf_write_en_q <= 1'b0;
                    state_q       <= WB_IDLE;
                end
                default: begin
                    rf_write_en_q <= 1'b0;
                    state_q       <= WB_IDLE;
                end
            endcase
        end
    end

    assign rf_write_en  = rf_write_en_q;
    assign rf_a3        = rf_a3_q;
    assign rf_opcode    = rf_opcode_q;
    assign rf_writedata = rf_writedata_q;

`ifdef MIPS_WB_FORWARD_EN
    assign fwd_valid  = rf_write_en_q;
    assign fwd_reg    = rf_a3_q;
    assign fwd_data   = rf_writedata_q;
    assign pend_valid = (state_q == WB_WAIT_MEM);
    assign pend_reg   = (state_q == WB_WAIT_MEM) ? rf_a3_q : 5'd0;
`endif

endmodule
